// File: rtl/seq_divider_hs.sv
// Multi-cycle restoring divider with start/busy/done handshake and divide-by-zero flag.
// Define SIGNED_DIV_EN to add the signed_mode input and the FIX (sign-correction) state.
module seq_divider_hs #(
  parameter int WIDTH_A = 8,
  parameter int WIDTH_B = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
`ifdef SIGNED_DIV_EN
  input  logic               signed_mode,
`endif
  input  logic [WIDTH_A-1:0] A,
  input  logic [WIDTH_B-1:0] B,
  output logic [WIDTH_A-1:0] Q,
  output logic [WIDTH_B-1:0] R,
  output logic               busy,
  output logic               done,
  output logic               dbz
);

  localparam int CNT_W = (WIDTH_A > 1) ? $clog2(WIDTH_A) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH_A - 1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_FIX} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t             state, state_d;
  logic [WIDTH_A-1:0] a_reg;     // remaining dividend; quotient bits fill in from the LSB
  logic [WIDTH_B-1:0] b_reg;
  logic [WIDTH_B-1:0] p;         // stored partial remainder, always < divisor
  logic [CNT_W-1:0]   count;

  logic               accept;
  logic               b_zero;
  logic               last;
  logic [WIDTH_B:0]   p_shift;   // WIDTH_B+1-bit trial remainder
  logic               q_bit;
  logic [WIDTH_B-1:0] p_next;
  logic [WIDTH_A-1:0] q_next;
  logic [WIDTH_A-1:0] a_mag;
  logic [WIDTH_B-1:0] b_mag;

`ifdef SIGNED_DIV_EN
  logic mode_r;
  logic neg_q;
  logic neg_r;
`endif

  assign accept  = start && (state == S_IDLE || state == S_DONE);
  assign b_zero  = (B == '0);
  assign last    = (state == S_RUN) && (count == LAST);
  assign p_shift = {p, a_reg[WIDTH_A-1]};
  assign q_bit   = (p_shift >= {1'b0, b_reg});
  assign p_next  = q_bit ? WIDTH_B'(p_shift - {1'b0, b_reg}) : p_shift[WIDTH_B-1:0];
  assign q_next  = {a_reg[WIDTH_A-2:0], q_bit};

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    a_mag = A;
    b_mag = B;
`ifdef SIGNED_DIV_EN
    if (signed_mode && A[WIDTH_A-1]) a_mag = -A;
    if (signed_mode && B[WIDTH_B-1]) b_mag = -B;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start)                state_d = b_zero ? S_DONE : S_RUN;
        else if (state == S_DONE) state_d = S_IDLE;
      end
      S_RUN: begin
`ifdef SIGNED_DIV_EN
        if (last) state_d = mode_r ? S_FIX : S_DONE;
`else
        if (last) state_d = S_DONE;
`endif
      end
`ifdef SIGNED_DIV_EN
      S_FIX:   state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      p      <= '0;
      count  <= '0;
      Q      <= '0;
      R      <= '0;
      dbz    <= 1'b0;
`ifdef SIGNED_DIV_EN
      mode_r <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else if (accept) begin
      a_reg <= a_mag;
      b_reg <= b_mag;
      p     <= '0;
      count <= '0;
      // Divide-by-zero completes immediately from the raw operands; Q/R otherwise hold.
      if (b_zero) begin
        Q   <= '1;
        R   <= A[WIDTH_B-1:0];
        dbz <= 1'b1;
      end
`ifdef SIGNED_DIV_EN
      mode_r <= signed_mode;
      neg_q  <= signed_mode && (A[WIDTH_A-1] ^ B[WIDTH_B-1]);
      neg_r  <= signed_mode && A[WIDTH_A-1];
`endif
    end else if (state == S_RUN) begin
      p     <= p_next;
      a_reg <= q_next;
      count <= count + 1'b1;
      if (last) begin
        Q   <= q_next;
        R   <= p_next;
        dbz <= 1'b0;
      end
`ifdef SIGNED_DIV_EN
    end else if (state == S_FIX) begin
      // Truncation toward zero: quotient sign from operand signs, remainder follows dividend.
      if (neg_q) Q <= -Q;
      if (neg_r) R <= -R;
`endif
    end
  end

endmodule

// File: tb/tb_seq_divider_hs.sv
// Scoreboard bench for seq_divider_hs (WIDTH_A=8, WIDTH_B=4); signed cases run when SIGNED_DIV_EN is defined.
module tb_seq_divider_hs;

  localparam int WA = 8;
  localparam int WB = 4;

  typedef struct packed {
    logic [WA-1:0] q;
    logic [WB-1:0] r;
    logic          dbz;
  } res_t;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [WA-1:0] a;
  logic [WB-1:0] b;
  logic [WA-1:0] q;
  logic [WB-1:0] r;
  logic          busy;
  logic          done;
  logic          dbz;
`ifdef SIGNED_DIV_EN
  logic          signed_mode;
`endif

  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;
  res_t sb[$];
  res_t mon_e;

  seq_divider_hs #(.WIDTH_A(WA), .WIDTH_B(WB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef SIGNED_DIV_EN
    .signed_mode(signed_mode),
`endif
    .A          (a),
    .B          (b),
    .Q          (q),
    .R          (r),
    .busy       (busy),
    .done       (done),
    .dbz        (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic res_t model(input logic [WA-1:0] ai, input logic [WB-1:0] bi, input bit sm);
    res_t e;
    int   sa, sbv, qi, ri;
    if (bi == '0) begin
      e.q   = '1;
      e.r   = ai[WB-1:0];
      e.dbz = 1'b1;
    end else if (sm) begin
      sa    = int'($signed(ai));
      sbv   = int'($signed(bi));
      qi    = sa / sbv;
      ri    = sa % sbv;
      e.q   = qi[WA-1:0];
      e.r   = ri[WB-1:0];
      e.dbz = 1'b0;
    end else begin
      qi    = int'(ai) / int'(bi);
      ri    = int'(ai) % int'(bi);
      e.q   = qi[WA-1:0];
      e.r   = ri[WB-1:0];
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Every done pulse consumes exactly one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("Q", q, mon_e.q);
        check("R", r, mon_e.r);
        check("dbz", dbz, mon_e.dbz);
      end
    end
  end

  task automatic op(input logic [WA-1:0] ai, input logic [WB-1:0] bi, input bit sm,
                    input bit chained, input int poke_at, input bit hold_chk, input res_t hold_v);
    int n, busy_n, exp_n;
    if (!chained) @(negedge clk);
    a     = ai;
    b     = bi;
    start = 1'b1;
`ifdef SIGNED_DIV_EN
    signed_mode = sm;
`endif
    sb.push_back(model(ai, bi, sm));
    @(negedge clk);
    start  = 1'b0;
    n      = 0;
    busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if (n == poke_at) begin
        a     = 8'd9;
        b     = 4'd3;
        start = 1'b1;
      end
      if (hold_chk && n == 4) begin
        check("hold_Q", q, hold_v.q);
        check("hold_R", r, hold_v.r);
        check("hold_dbz", dbz, hold_v.dbz);
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    exp_n = (bi == '0) ? 0 : (sm ? WA + 1 : WA);
    check("latency", n, exp_n);
    check("busy_cycles", busy_n, (bi == '0) ? 0 : WA);
  endtask

  res_t none;
  res_t prev;

  initial begin
    none  = '0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
`ifdef SIGNED_DIV_EN
    signed_mode = 1'b0;
`endif
    #1;
    check("rst_Q", q, 0);
    check("rst_R", r, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", dbz, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    op(8'd200, 4'd7, 1'b0, 1'b0, -1, 1'b0, none);
    op(8'd13,  4'd0, 1'b0, 1'b0, -1, 1'b0, none);
    // Second request at cycle 3 of a run must be ignored.
    op(8'd255, 4'd15, 1'b0, 1'b0, 3, 1'b0, none);
    repeat (3) @(negedge clk);
    check("single_done", done_cnt, 3);
    // Back-to-back: restart during DONE, previous result held meanwhile.
    op(8'd255, 4'd15, 1'b0, 1'b0, -1, 1'b0, none);
    prev = '{q: 8'd17, r: 4'd0, dbz: 1'b0};
    op(8'd9, 4'd2, 1'b0, 1'b1, -1, 1'b1, prev);

    op(8'd0,   4'd1,  1'b0, 1'b0, -1, 1'b0, none);
    op(8'd255, 4'd1,  1'b0, 1'b0, -1, 1'b0, none);
    op(8'd7,   4'd15, 1'b0, 1'b0, -1, 1'b0, none);
    op(8'd13,  4'd0,  1'b0, 1'b0, -1, 1'b0, none);

    // Reset at cycle 4 of a run discards it and clears the outputs at once.
    @(negedge clk);
    a     = 8'd255;
    b     = 4'd15;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_Q", q, 0);
    check("mid_rst_R", r, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_busy", busy, 0);
    op(8'd200, 4'd7, 1'b0, 1'b0, -1, 1'b0, none);

    for (int i = 0; i < 24; i++) begin
      op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b0, (i % 2) == 1, -1, 1'b0, none);
    end

`ifdef SIGNED_DIV_EN
    op(8'h9C, 4'd7, 1'b1, 1'b0, -1, 1'b0, none);
    op(8'h80, 4'hF, 1'b1, 1'b0, -1, 1'b0, none);
    op(8'h80, 4'hF, 1'b0, 1'b0, -1, 1'b0, none);
    op(8'h85, 4'h0, 1'b1, 1'b0, -1, 1'b0, none);
    for (int i = 0; i < 16; i++) begin
      op(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 1'b1, (i % 2) == 1, -1, 1'b0, none);
    end
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider_hs.md
Name: seq_divider_hs

Overview:
Parametrised multi-cycle restoring divider with a start/busy/done handshake, asynchronous reset and divide-by-zero detection. It is the next generation of the team's free-running shift-subtract divider. It accepts a new operand pair on request, produces one quotient bit per clock, and holds the result until the next operation. It is intended for the readout/calibration datapaths, where a controller issues divisions back-to-back.

Parameters:
WIDTH_A, 8, dividend and quotient width in bits (>=2)
WIDTH_B, 4, divisor and remainder width in bits (>=2, <=WIDTH_A)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request a division; sampled on clk rising edge
A  input  WIDTH_A  dividend; sampled only on the edge that accepts start
B  input  WIDTH_B  divisor; sampled only on the edge that accepts start
Q  output  WIDTH_A  quotient, registered
R  output  WIDTH_B  remainder, registered
busy  output  1  high while an accepted division is iterating
done  output  1  one-cycle pulse; Q/R/dbz valid from this cycle onward
dbz  output  1  divide-by-zero flag, valid with done, held with Q/R

Behaviour:
- Reset (rst_n low, asynchronous, any state, including mid-operation): state IDLE; Q=0, R=0, busy=0, done=0, dbz=0, counter=0. The operation in progress is discarded.
- States:
  - IDLE
  - RUN
  - FIX (exists only with SIGNED_DIV_EN)
  - DONE
- IDLE or DONE with start=1:
  - Latch A and B.
  - If B!=0: clear the partial remainder, counter=0, go to RUN, busy=1.
  - If B==0: go to DONE; Q=all ones, R=A[WIDTH_B-1:0], dbz=1, busy stays 0.
- IDLE or DONE with start=0: DONE returns to IDLE.
- done=1 only in the DONE state. It is never asserted in IDLE.
- RUN, one step per edge:
  - Shift the MSB of the remaining dividend into a WIDTH_B+1-bit partial remainder P.
  - If P>=B: P=P-B and shift 1 into the quotient. Otherwise shift 0.
  - counter+1.
  - The step with counter==WIDTH_A-1 is the last. On that edge: Q and R (P[WIDTH_B-1:0]) update, dbz=0, busy=0, state goes to DONE (or FIX in signed mode).
- Latency, unsigned: done is high in the cycle following the WIDTH_A-th edge after the accepting edge. Divide-by-zero latency is 1 edge.
- start while busy=1 is ignored, with no effect on the operation.
- start during the DONE cycle is accepted, giving back-to-back operation. done lasts exactly one cycle regardless.
- Q, R and dbz hold their last values until the next completion or reset. They are not cleared when a new operation starts.
- P never exceeds WIDTH_B+1 bits. Results are exact for all unsigned operands: A = Q*B + R, R < B.

Optional Feature:
Macro: SIGNED_DIV_EN
- Defined:
  - Adds input port signed_mode (1 bit), sampled with start.
  - When signed_mode=1, A and B are two's complement. The core divides the magnitudes.
  - FIX state, one extra cycle: negate Q if the operand signs differ; negate R if A is negative.
  - Result truncates toward zero; the remainder takes the sign of the dividend.
  - Signed latency is WIDTH_A+1 edges.
  - Overflow case, most-negative A divided by -1: Q=most-negative value (wrap), R=0, dbz=0.
  - signed_mode=0 behaves exactly as the unsigned build.
  - Divide-by-zero behaviour is unchanged in either mode.
- Undefined: the signed_mode port is absent and no FIX state is synthesised. Operation is unsigned only.

Test Plan:
- WIDTH_A=8, WIDTH_B=4; A=200, B=7, start pulse → busy high for 8 cycles; done pulses 8 edges after acceptance; Q=28, R=4, dbz=0.
- A=13, B=0 → done on the next cycle; dbz=1, Q=0xFF, R=0xD; busy never asserts.
- A=255, B=15 accepted, then start with A=9, B=3 asserted at cycle 3 → second request ignored; Q=17, R=0; exactly one done pulse.
- Back-to-back: start held through DONE with A=9, B=2 → second done exactly 8 edges later; Q=4, R=1; first result (Q=17, R=0) held until then.
- Reset: rst_n pulsed low at cycle 4 of a run → immediately Q=0, R=0, busy=0, done=0; no done afterwards; a fresh start after release completes correctly.
- SIGNED_DIV_EN, signed_mode=1: A=-100 (0x9C), B=7 → Q=-14 (0xF2), R=-2 (0xE), done after 9 edges. Also A=-128, B=-1 → Q=0x80, R=0.
